iteration_uart_sender: RTL and testbench

- Downstream consumer of the parser's sensor-iteration output.
- Waits for `sensor_data_avl`, captures the 102-bit `sensor_iterations` word, and acknowledges it by asserting `reset_parser` until the parser withdraws `sensor_data_avl`.
- Serialises the captured word as a framed, checksummed UART 8N1 packet on `tx`.
- Sits between the data parser and the tracker's host-facing UART pin.

---
 rtl/iteration_uart_sender_pkg.sv | 20 ++
 rtl/iteration_uart_sender_uart_tx_byte.sv | 88 ++++++++
 rtl/iteration_uart_sender.sv | 148 ++++++++++++++
 tb/tb_iteration_uart_sender.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iteration_uart_sender_pkg.sv
// Shared constants and FSM encoding for the sensor-iteration UART sender.
// The iteration and triad widths are common with the data parser.
package iteration_uart_sender_pkg;

  localparam int ITER_WIDTH       = 102;
  localparam int TRIAD_WIDTH      = 68;
  localparam int FRAME_DATA_BYTES = 13;
  localparam int WORD_WIDTH       = 8 * FRAME_DATA_BYTES;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ACK       = 3'd1,
    ST_SEND_SYNC = 3'd2,
    ST_WAIT_BYTE = 3'd3,
    ST_WAIT_LAST = 3'd4
  } state_t;

endpackage

// File: rtl/iteration_uart_sender_uart_tx_byte.sv
// UART 8N1 byte transmitter. done pulses in the final cycle of the stop bit, and a
// new start is accepted in that same cycle so consecutive bytes leave without a gap.
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 625
) (
  input  logic       clk_72MHz,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       done,
  output logic       busy
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_ONE      = CW'(1);
  localparam logic [CW-1:0] CNT_LAST     = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_STOP_END = CW'(CLKS_PER_BIT - 2);
  localparam logic [3:0]    BIT_STOP     = 4'd9;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  // Bit sequencing: start bit, 8 data bits LSB first, stop bit.
  always_comb begin
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (start && !busy_q) begin
      shift_d = data;
      tx_d    = 1'b0;
      busy_d  = 1'b1;
      bit_d   = 4'd0;
      cnt_d   = {CW{1'b0}};
    end else if (busy_q) begin
      // The last stop cycle runs with busy low so the next start lands on the bit boundary.
      if (bit_q == BIT_STOP && cnt_q == CNT_STOP_END) begin
        busy_d = 1'b0;
        done_d = 1'b1;
        cnt_d  = {CW{1'b0}};
      end else if (cnt_q == CNT_LAST) begin
        cnt_d = {CW{1'b0}};
        bit_d = bit_q + 4'd1;
        if (bit_q < 4'd8) begin
          tx_d    = shift_q[0];
          shift_d = {1'b0, shift_q[7:1]};
        end else begin
          tx_d = 1'b1;
        end
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end else begin
      tx_d = 1'b1;
    end
  end

  // Transmitter state registers; line idles high.
  always_ff @(posedge clk_72MHz or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= {CW{1'b0}};
      bit_q   <= 4'd0;
      shift_q <= 8'h00;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign tx   = tx_q;
  assign done = done_q;
  assign busy = busy_q;

endmodule

// File: rtl/iteration_uart_sender.sv
// Captures a parser iteration word, acknowledges it, and sends it as a
// SYNC + 13 data bytes + XOR checksum UART frame.
module iteration_uart_sender
  import iteration_uart_sender_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 625,
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT,
  parameter int         ACK_TIMEOUT  = 255
) (
  input  logic                  clk_72MHz,
  input  logic                  reset_n,
  input  logic [ITER_WIDTH-1:0] sensor_iterations,
  input  logic                  sensor_data_avl,
  output logic                  reset_parser,
  output logic                  tx,
  output logic                  busy
);

  localparam logic [15:0] ACK_LAST   = 16'(ACK_TIMEOUT - 1);
  localparam logic [3:0]  DATA_BYTES = 4'(FRAME_DATA_BYTES);

  state_t                state_q, state_d;
  logic                  avl_q;
  logic [WORD_WIDTH-1:0] word_q, word_d;
  logic [7:0]            csum_q, csum_d;
  logic [3:0]            idx_q, idx_d;
  logic [15:0]           timer_q, timer_d;
  logic                  busy_q, busy_d;
  logic                  rp_q, rp_d;
  logic                  start_s;
  logic [7:0]            byte_s;
  logic                  tx_done_s;
  logic                  tx_busy_s;

  // Frame sequencing and parser handshake.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    csum_d  = csum_q;
    idx_d   = idx_q;
    timer_d = timer_q;
    busy_d  = busy_q;
    rp_d    = rp_q;
    start_s = 1'b0;
    byte_s  = 8'h00;
    case (state_q)
      ST_IDLE: begin
        if (avl_q) begin
          word_d  = {{(WORD_WIDTH-ITER_WIDTH){1'b0}}, sensor_iterations};
          csum_d  = 8'h00;
          timer_d = 16'h0000;
          busy_d  = 1'b1;
          rp_d    = 1'b1;
          state_d = ST_ACK;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACK: begin
        if (!avl_q || timer_q == ACK_LAST) begin
          rp_d    = 1'b0;
          state_d = ST_SEND_SYNC;
        end else begin
          timer_d = timer_q + 16'h0001;
        end
      end
      ST_SEND_SYNC: begin
        if (!tx_busy_s) begin
          start_s = 1'b1;
          byte_s  = SYNC_BYTE;
          idx_d   = 4'd0;
          state_d = ST_WAIT_BYTE;
        end else begin
          state_d = ST_SEND_SYNC;
        end
      end
      // The next byte is issued on the done pulse itself, so the line never idles mid-frame.
      ST_WAIT_BYTE: begin
        if (tx_done_s) begin
          start_s = 1'b1;
          if (idx_q < DATA_BYTES) begin
            byte_s  = word_q[WORD_WIDTH-1 -: 8];
            csum_d  = csum_q ^ word_q[WORD_WIDTH-1 -: 8];
            word_d  = {word_q[WORD_WIDTH-9:0], 8'h00};
            idx_d   = idx_q + 4'd1;
          end else begin
            byte_s  = csum_q;
            state_d = ST_WAIT_LAST;
          end
        end else begin
          state_d = ST_WAIT_BYTE;
        end
      end
      ST_WAIT_LAST: begin
        if (tx_done_s) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT_LAST;
        end
      end
      default: begin
        busy_d  = 1'b0;
        rp_d    = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, capture and handshake registers.
  always_ff @(posedge clk_72MHz or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      avl_q   <= 1'b0;
      word_q  <= {WORD_WIDTH{1'b0}};
      csum_q  <= 8'h00;
      idx_q   <= 4'd0;
      timer_q <= 16'h0000;
      busy_q  <= 1'b0;
      rp_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      avl_q   <= sensor_data_avl;
      word_q  <= word_d;
      csum_q  <= csum_d;
      idx_q   <= idx_d;
      timer_q <= timer_d;
      busy_q  <= busy_d;
      rp_q    <= rp_d;
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk_72MHz(clk_72MHz),
    .reset_n  (reset_n),
    .start    (start_s),
    .data     (byte_s),
    .tx       (tx),
    .done     (tx_done_s),
    .busy     (tx_busy_s)
  );

  assign reset_parser = rp_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_iteration_uart_sender.sv
// Scoreboard bench for iteration_uart_sender: frames are decoded from tx and
// compared byte by byte against expected frames queued when words are offered.
module tb_iteration_uart_sender;

  localparam int CPB        = 16;
  localparam int WAIT_LIMIT = 40 * CPB;

  logic         clk_72MHz = 1'b0;
  logic         reset_n;
  logic [101:0] sensor_iterations;
  logic         sensor_data_avl;
  logic         reset_parser;
  logic         tx;
  logic         busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [7:0] exp_q[$];

  iteration_uart_sender #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk_72MHz        (clk_72MHz),
    .reset_n          (reset_n),
    .sensor_iterations(sensor_iterations),
    .sensor_data_avl  (sensor_data_avl),
    .reset_parser     (reset_parser),
    .tx               (tx),
    .busy             (busy)
  );

  always #5 clk_72MHz = ~clk_72MHz;

  always @(posedge clk_72MHz) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic push_frame(input logic [101:0] w);
    logic [103:0] x;
    logic [7:0]   c;
    x = {2'b00, w};
    c = 8'h00;
    exp_q.push_back(8'hA5);
    for (int i = 0; i < 13; i++) begin
      exp_q.push_back(x[103-8*i -: 8]);
      c = c ^ x[103-8*i -: 8];
    end
    exp_q.push_back(c);
  endtask

  // Parser model: wait for the acknowledge, drop avl on the drop_after-th observed
  // cycle (0 = never), and return how many cycles reset_parser stayed high.
  task automatic parser_ack(input int drop_after, output int hi);
    int n;
    n = 0;
    while (reset_parser !== 1'b1 && n < 50) begin
      @(negedge clk_72MHz);
      n++;
    end
    hi = 0;
    while (reset_parser === 1'b1 && hi < 1000) begin
      hi++;
      if (hi == drop_after) sensor_data_avl = 1'b0;
      @(negedge clk_72MHz);
    end
  endtask

  task automatic get_byte(output logic [7:0] b, output int idle, output bit stable,
                          output logic stopb, output int st, output bit ok);
    logic [9:0] bits;
    idle   = 0;
    stable = 1'b1;
    bits   = 10'h3FF;
    st     = 0;
    @(negedge clk_72MHz);
    while (tx !== 1'b0 && idle < WAIT_LIMIT) begin
      idle++;
      @(negedge clk_72MHz);
    end
    ok = (tx === 1'b0);
    if (ok) begin
      st = cyc;
      for (int k = 0; k < 10; k++) begin
        for (int c = 0; c < CPB; c++) begin
          if (k != 0 || c != 0) @(negedge clk_72MHz);
          if (c == 0) bits[k] = tx;
          else if (tx !== bits[k]) stable = 1'b0;
        end
      end
    end
    b     = bits[8:1];
    stopb = bits[9];
  endtask

  task automatic recv_frame(input string name);
    logic [7:0] b;
    logic [7:0] e;
    logic       stopb;
    int         idle, st, st0, span;
    bit         stable, ok;
    st0 = 0;
    st  = 0;
    for (int i = 0; i < 15; i++) begin
      get_byte(b, idle, stable, stopb, st, ok);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      total++;
      if (!ok) begin
        bad++;
        $display("FAIL %s byte%0d: no start bit within %0d cycles, expected byte %h", name, i, WAIT_LIMIT, e);
        for (int j = i + 1; j < 15; j++) if (exp_q.size() > 0) e = exp_q.pop_front();
        return;
      end
      if (i == 0) st0 = st;
      total++;
      if (b !== e) begin
        bad++;
        $display("FAIL %s byte%0d: got %h expected %h", name, i, b, e);
      end
      total++;
      if (stopb !== 1'b1) begin
        bad++;
        $display("FAIL %s stop%0d: got %b expected 1", name, i, stopb);
      end
      total++;
      if (!stable) begin
        bad++;
        $display("FAIL %s bit_timing%0d: a bit did not last exactly %0d cycles", name, i, CPB);
      end
      total++;
      if ((i == 0) ? (idle > 2) : (idle != 0)) begin
        bad++;
        $display("FAIL %s gap%0d: idle cycles before start bit %0d, expected %s", name, i, idle,
                 (i == 0) ? "<=2" : "0");
      end
    end
    span = st - st0 + 10 * CPB;
    total++;
    if (span != 150 * CPB) begin
      bad++;
      $display("FAIL %s frame_span: got %0d cycles expected %0d", name, span, 150 * CPB);
    end
    @(negedge clk_72MHz);
    total++;
    if (busy !== 1'b0 || tx !== 1'b1) begin
      bad++;
      $display("FAIL %s post_frame: busy=%b tx=%b expected busy=0 tx=1", name, busy, tx);
    end
  endtask

  task automatic test_reset();
    reset_n           = 1'b0;
    sensor_data_avl   = 1'b0;
    sensor_iterations = 102'h0;
    repeat (3) @(negedge clk_72MHz);
    total++;
    if (tx !== 1'b1) begin bad++; $display("FAIL reset_tx: got %b expected 1", tx); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
    total++;
    if (reset_parser !== 1'b0) begin bad++; $display("FAIL reset_ack: got %b expected 0", reset_parser); end
    reset_n = 1'b1;
    repeat (4) @(negedge clk_72MHz);
    total++;
    if (busy !== 1'b0 || tx !== 1'b1) begin
      bad++;
      $display("FAIL idle_after_reset: busy=%b tx=%b expected busy=0 tx=1", busy, tx);
    end
  endtask

  task automatic test_single_word();
    int hi;
    sensor_iterations = 102'h2_AAAA_5555_1234_5678_9ABC_DEF0;
    sensor_data_avl   = 1'b1;
    push_frame(sensor_iterations);
    parser_ack(2, hi);
    total++;
    if (hi < 3 || hi > 4) begin bad++; $display("FAIL single_ack_len: got %0d expected 3..4", hi); end
    recv_frame("single");
  endtask

  task automatic test_back_pressure();
    int  hi, n;
    bit  early;
    sensor_iterations = 102'h1_0F0F_3C3C_A5A5_0000_FFFF_8001;
    sensor_data_avl   = 1'b1;
    push_frame(sensor_iterations);
    parser_ack(2, hi);
    early = 1'b0;
    n     = 0;
    fork
      recv_frame("bp_first");
      begin
        repeat (1000) @(negedge clk_72MHz);
        sensor_iterations = 102'h3F_0123_4567_89AB_CDEF_FEDC_BA98;
        sensor_data_avl   = 1'b1;
        push_frame(sensor_iterations);
        while (busy === 1'b1 && n < 4000) begin
          if (reset_parser === 1'b1) early = 1'b1;
          @(negedge clk_72MHz);
          n++;
        end
      end
    join
    total++;
    if (early) begin bad++; $display("FAIL bp_no_ack_while_busy: reset_parser=1 seen expected 0"); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL bp_busy_fall: got %b expected 0", busy); end
    parser_ack(2, hi);
    total++;
    if (hi < 3 || hi > 4) begin bad++; $display("FAIL bp_second_ack_len: got %0d expected 3..4", hi); end
    recv_frame("bp_second");
  endtask

  task automatic test_stuck_parser();
    int hi;
    sensor_iterations = 102'h15_5555_AAAA_0F0F_F0F0_1357_9BDF;
    sensor_data_avl   = 1'b1;
    push_frame(sensor_iterations);
    parser_ack(0, hi);
    total++;
    if (hi != 255) begin bad++; $display("FAIL stuck_ack_timeout: got %0d expected 255", hi); end
    recv_frame("stuck_first");
    push_frame(sensor_iterations);
    parser_ack(1, hi);
    total++;
    if (hi < 1) begin bad++; $display("FAIL stuck_recapture: ack cycles %0d expected >=1", hi); end
    recv_frame("stuck_recaptured");
  endtask

  task automatic test_reset_mid_frame();
    int hi, n;
    sensor_iterations = 102'h1_1111_2222_3333_4444_5555_6666;
    sensor_data_avl   = 1'b1;
    parser_ack(2, hi);
    repeat (6 * 10 * CPB + 3 * CPB) @(negedge clk_72MHz);
    n = 0;
    while (tx !== 1'b0 && n < 20 * CPB) begin
      @(negedge clk_72MHz);
      n++;
    end
    total++;
    if (busy !== 1'b1 || tx !== 1'b0) begin
      bad++;
      $display("FAIL mid_frame_pre: busy=%b tx=%b expected busy=1 tx=0", busy, tx);
    end
    reset_n = 1'b0;
    #1;
    total++;
    if (tx !== 1'b1) begin bad++; $display("FAIL mid_reset_tx: got %b expected 1", tx); end
    total++;
    if (reset_parser !== 1'b0) begin bad++; $display("FAIL mid_reset_ack: got %b expected 0", reset_parser); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL mid_reset_busy: got %b expected 0", busy); end
    sensor_iterations = 102'h0_DEAD_BEEF_CAFE_F00D_8421_7EB1;
    sensor_data_avl   = 1'b1;
    push_frame(sensor_iterations);
    repeat (2) @(negedge clk_72MHz);
    reset_n = 1'b1;
    parser_ack(2, hi);
    total++;
    if (hi < 3 || hi > 4) begin bad++; $display("FAIL post_reset_ack_len: got %0d expected 3..4", hi); end
    recv_frame("after_reset");
  endtask

  task automatic test_all_zero();
    int hi;
    sensor_iterations = 102'h0;
    sensor_data_avl   = 1'b1;
    push_frame(sensor_iterations);
    parser_ack(2, hi);
    total++;
    if (hi < 3 || hi > 4) begin bad++; $display("FAIL zero_ack_len: got %0d expected 3..4", hi); end
    recv_frame("all_zero");
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_pressure();
    test_stuck_parser();
    test_reset_mid_frame();
    test_all_zero();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_leftover: %0d bytes still expected, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
